// File: rtl/uart_tx_pkg.sv
// Shared definitions for the multi-frame UART transmitter: FSM state
// encodings, byte width and frame-count helper.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam int unsigned BITS_PER_BYTE = 8;

   function automatic int unsigned num_frames(input int unsigned data_w);
      return data_w / BITS_PER_BYTE;
   endfunction

endpackage

// File: rtl/uart_tx_multiframe_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Synchronous clear holds the count at zero while idle.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_end
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] baud_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_cnt <= '0;
      end else if (clear || baud_cnt == LAST_CNT) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + CW'(1);
      end
   end

   assign bit_end = (baud_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_multiframe.sv
// Parametrised UART transmitter sending a DATA_W-bit word as DATA_W/8
// back-to-back frames. Optional parity bit enabled by UART_TX_PARITY_EN.
module uart_tx_multiframe
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   output logic              out,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_out
);

   localparam int unsigned NF = num_frames(DATA_W);
   localparam int unsigned FW = $clog2(NF) + 1;
   localparam logic [FW-1:0] LAST_FRAME = FW'(NF - 1);
   localparam logic [2:0]    LAST_STOP  = 3'(STOP_BITS - 1);

   if (DATA_W < 8 || (DATA_W % 8) != 0 || CLKS_PER_BIT < 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_cfg_err
      $error("uart_tx_multiframe: illegal parameter combination");
   end

   tx_state_e         state_q, state_d;
   logic              out_q, out_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [FW-1:0]     frame_idx_q, frame_idx_d;
   logic              bit_end;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == ST_IDLE),
      .bit_end(bit_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         out_q       <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         shreg_q     <= '0;
         bit_idx_q   <= '0;
         frame_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         shreg_q     <= shreg_d;
         bit_idx_q   <= bit_idx_d;
         frame_idx_q <= frame_idx_d;
`ifdef UART_TX_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      shreg_d     = shreg_q;
      bit_idx_d   = bit_idx_q;
      frame_idx_d = frame_idx_q;
`ifdef UART_TX_PARITY_EN
      par_d       = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_d     = data;
               out_d       = 1'b0;
               busy_d      = 1'b1;
               state_d     = ST_START;
               bit_idx_d   = '0;
               frame_idx_d = '0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               out_d     = shreg_q[0];
               state_d   = ST_DATA;
               bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
               par_d     = (^shreg_q[7:0]) ^ (PARITY_ODD != 0);
`endif
            end
         end
         // The shifter consumes one bit per data slot, so after bit 7 the
         // next frame's byte already sits in shreg_q[7:0].
         ST_DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = ST_PARITY;
                  out_d     = par_q;
`else
                  state_d   = ST_STOP;
                  out_d     = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  out_d     = shreg_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d   = ST_STOP;
               out_d     = 1'b1;
               bit_idx_d = '0;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (bit_idx_q == LAST_STOP) begin
                  bit_idx_d = '0;
                  if (frame_idx_q != LAST_FRAME) begin
                     frame_idx_d = frame_idx_q + FW'(1);
                     state_d     = ST_START;
                     out_d       = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            out_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign out       = out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_uart_tx_multiframe.sv
// Self-checking bench for uart_tx_multiframe: two instances (1 stop/even,
// 2 stop/odd) checked cycle by cycle against a frame-list reference model.
module tb_uart_tx_multiframe;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        drv_start;
   logic [15:0] drv_data;
   int          sel;

   logic        start1, start2;
   logic        out1, busy1, done1;
   logic        out2, busy2, done2;
   logic [2:0]  st1, st2;
   logic        obs_out, obs_busy, obs_done;
   logic [2:0]  obs_st;

   int n_checks = 0;
   int n_err    = 0;
   int exp_bits[$];

   always #5 clk = ~clk;

   assign start1 = drv_start && (sel == 0);
   assign start2 = drv_start && (sel == 1);

   always_comb begin
      obs_out  = (sel == 0) ? out1  : out2;
      obs_busy = (sel == 0) ? busy1 : busy2;
      obs_done = (sel == 0) ? done1 : done2;
      obs_st   = (sel == 0) ? st1   : st2;
   end

   uart_tx_multiframe #(
      .DATA_W(16), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)
   ) dut1 (
      .clk(clk), .reset(reset), .start(start1), .data(drv_data),
      .out(out1), .busy(busy1), .done(done1), .state_out(st1)
   );

   uart_tx_multiframe #(
      .DATA_W(16), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)
   ) dut2 (
      .clk(clk), .reset(reset), .start(start2), .data(drv_data),
      .out(out2), .busy(busy2), .done(done2), .state_out(st2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: list of line levels, one entry per bit-time.
   function automatic void build_frames(input logic [15:0] w, input int sb,
                                        input int podd);
      exp_bits.delete();
      for (int f = 0; f < 2; f++) begin
         int byte_v = (int'(w) >> (8 * f)) % 256;
         int ones   = 0;
         exp_bits.push_back(0);
         for (int b = 0; b < 8; b++) begin
            int bv = (byte_v >> b) % 2;
            exp_bits.push_back(bv);
            ones += bv;
         end
`ifdef UART_TX_PARITY_EN
         exp_bits.push_back((ones + podd) % 2);
`endif
         for (int s = 0; s < sb; s++) exp_bits.push_back(1);
      end
   endfunction

   task automatic check_idle(input string tag);
      check_eq({tag, "_out"},   obs_out,  1);
      check_eq({tag, "_busy"},  obs_busy, 0);
      check_eq({tag, "_done"},  obs_done, 0);
      check_eq({tag, "_state"}, obs_st,   0);
   endtask

   // Precondition: called just after a negedge with the selected DUT idle.
   task automatic run_word(input string tag, input logic [15:0] w,
                           input bit chain, input bit disturb);
      int len;
      build_frames(w, (sel == 0) ? 1 : 2, (sel == 0) ? 0 : 1);
      len = exp_bits.size() * CPB;
      drv_data  = w;
      drv_start = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc < len; cyc++) begin
         @(negedge clk);
         if (cyc == 0) drv_start = 1'b0;
         if (disturb && cyc == 0)  drv_data  = 16'($urandom);
         if (disturb && cyc == 10) drv_start = 1'b1;
         if (disturb && cyc == 11) drv_start = 1'b0;
         if (chain && cyc == len - 2) drv_start = 1'b1;
         check_eq($sformatf("%s_line[%0d]", tag, cyc), obs_out, exp_bits[cyc / CPB]);
         check_eq($sformatf("%s_busy[%0d]", tag, cyc), obs_busy, 1);
         check_eq($sformatf("%s_done[%0d]", tag, cyc), obs_done, 0);
      end
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, obs_done, 1);
      check_eq({tag, "_busy_fall"},  obs_busy, 0);
      check_eq({tag, "_out_end"},    obs_out,  1);
      check_eq({tag, "_state_end"},  obs_st,   0);
      if (!chain) begin
         @(negedge clk);
         check_idle({tag, "_after"});
      end
   endtask

   task automatic run_abort(input logic [15:0] w);
      build_frames(w, 1, 0);
      drv_data  = w;
      drv_start = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc <= 30; cyc++) begin
         @(negedge clk);
         drv_start = 1'b0;
         check_eq($sformatf("abort_line[%0d]", cyc), obs_out, exp_bits[cyc / CPB]);
      end
      reset = 1'b1;
      #1;
      check_eq("abort_out",   obs_out,  1);
      check_eq("abort_busy",  obs_busy, 0);
      check_eq("abort_state", obs_st,   0);
      repeat (3) begin
         @(negedge clk);
         check_eq("abort_no_done", obs_done, 0);
      end
      reset = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         check_idle("abort_quiet");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      sel       = 0;
      reset     = 1'b1;
      drv_start = 1'b0;
      drv_data  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_idle("reset_idle");
      end
      sel = 1;
      check_idle("reset_idle2");
      sel = 0;

      run_word("a55a", 16'hA55A, 1'b0, 1'b0);
      run_word("p0307_even", 16'h0307, 1'b0, 1'b0);
      sel = 1;
      run_word("p0307_odd_sb2", 16'h0307, 1'b0, 1'b0);
      sel = 0;

      run_word("disturb", 16'($urandom), 1'b0, 1'b1);

      run_word("chain_a", 16'($urandom), 1'b1, 1'b0);
      run_word("chain_b", 16'($urandom), 1'b0, 1'b0);
      sel = 1;
      run_word("chain2_a", 16'($urandom), 1'b1, 1'b0);
      run_word("chain2_b", 16'($urandom), 1'b0, 1'b0);
      sel = 0;

      run_abort(16'($urandom));
      run_word("post_abort", 16'($urandom), 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         int gap = $urandom_range(0, 5);
         sel = $urandom_range(0, 1);
         repeat (gap) @(negedge clk);
         run_word($sformatf("rand%0d", i), 16'($urandom), 1'b0, ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
